// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Purpose  : Address/control sequencer for an in-place radix-2 DIF FFT.
//            Issues N/2 butterfly reads per stage with no bubbles, delays
//            the addresses through a pipeline to produce the write-back
//            strobes, and drains the butterfly between stages.
//            Optional bit-reversed unload: FFT_SEQ_BITREV_UNLOAD_EN
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
    parameter int N_POINTS   = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BF_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  bf_en,
    output logic [ADDR_WIDTH-2:0] twiddle_idx,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr_a,
    output logic [ADDR_WIDTH-1:0] wr_addr_b,
    output logic                  out_valid
);

    localparam int c_HALF = N_POINTS / 2;
    localparam int c_CW   = ADDR_WIDTH + 1;
    localparam int c_SW   = (ADDR_WIDTH > 1) ? $clog2(ADDR_WIDTH) : 1;
    localparam int c_WW   = $clog2(BF_LATENCY + 2);

`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_UNLOAD = 3'd3, S_FINISH = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_FINISH = 3'd4
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [c_SW-1:0]       stage_q, stage_d;
    logic [c_CW-1:0]       cnt_q, cnt_d;
    logic [c_WW-1:0]       wait_q, wait_d;

    logic                  busy_q, done_q;
    logic                  rd_en_q, rd_en_d;
    logic                  rd_issue_q, rd_issue_d;
    logic [ADDR_WIDTH-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [ADDR_WIDTH-2:0] rd_tw_q, rd_tw_d, tw_q;
    logic                  out_valid_q;

    // Delay line from read issue to write-back; entry 0 is the butterfly input.
    logic [BF_LATENCY:0]                 pen_q;
    logic [BF_LATENCY:0][ADDR_WIDTH-1:0] pa_q, pb_q;

    // span = N >> (s+1) == (N/2) >> s
    function automatic logic [ADDR_WIDTH-1:0] f_span(input logic [c_SW-1:0] s);
        return ADDR_WIDTH'(c_HALF) >> s;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] f_addr_a(input logic [c_SW-1:0] s,
                                                       input logic [ADDR_WIDTH-1:0] k);
        logic [ADDR_WIDTH-1:0] mask;
        mask = f_span(s) - 1'b1;
        // (k/span)*2*span + (k mod span), with span a power of two
        return ((k & ~mask) << 1) | (k & mask);
    endfunction

    function automatic logic [ADDR_WIDTH-2:0] f_twiddle(input logic [c_SW-1:0] s,
                                                        input logic [ADDR_WIDTH-1:0] k);
        logic [ADDR_WIDTH-1:0] t;
        t = (k & (f_span(s) - 1'b1)) << s;
        return t[ADDR_WIDTH-2:0];
    endfunction

`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    function automatic logic [ADDR_WIDTH-1:0] f_bitrev(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = v[ADDR_WIDTH-1-i];
        return r;
    endfunction
`endif

    // Next-state logic, then the next values of the registered read outputs.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    stage_d = '0;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (cnt_q == c_CW'(c_HALF - 1)) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (wait_q == c_WW'(BF_LATENCY)) begin
                    if (stage_q == c_SW'(ADDR_WIDTH - 1)) begin
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
                        state_d = S_UNLOAD;
                        cnt_d   = '0;
`else
                        state_d = S_FINISH;
`endif
                    end else begin
                        state_d = S_ISSUE;
                        stage_d = stage_q + 1'b1;
                        cnt_d   = '0;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
            // One extra cycle at cnt == N lets the last out_valid precede FINISH.
            S_UNLOAD: begin
                if (cnt_q == c_CW'(N_POINTS)) state_d = S_FINISH;
                else                          cnt_d   = cnt_q + 1'b1;
            end
`endif
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        rd_issue_d = (state_d == S_ISSUE);
        rd_en_d    = rd_issue_d;
        rd_a_d     = '0;
        rd_b_d     = '0;
        rd_tw_d    = '0;
        if (rd_issue_d) begin
            rd_a_d  = f_addr_a(stage_d, cnt_d[ADDR_WIDTH-1:0]);
            rd_b_d  = rd_a_d | f_span(stage_d);
            rd_tw_d = f_twiddle(stage_d, cnt_d[ADDR_WIDTH-1:0]);
        end
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
        if (state_d == S_UNLOAD && cnt_d < c_CW'(N_POINTS)) begin
            rd_en_d = 1'b1;
            rd_a_d  = f_bitrev(cnt_d[ADDR_WIDTH-1:0]);
        end
`endif
    end

    // Sequencer state: stage, butterfly/unload counter and drain counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Registered outputs and the address delay pipeline feeding write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_issue_q  <= 1'b0;
            rd_a_q      <= '0;
            rd_b_q      <= '0;
            rd_tw_q     <= '0;
            tw_q        <= '0;
            out_valid_q <= 1'b0;
            pen_q       <= '0;
            pa_q        <= '0;
            pb_q        <= '0;
        end else begin
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FINISH);
            rd_en_q     <= rd_en_d;
            rd_issue_q  <= rd_issue_d;
            rd_a_q      <= rd_a_d;
            rd_b_q      <= rd_b_d;
            rd_tw_q     <= rd_tw_d;
            tw_q        <= rd_tw_q;
            out_valid_q <= rd_en_q & ~rd_issue_q;
            pen_q[0]    <= rd_issue_q;
            pa_q[0]     <= rd_issue_q ? rd_a_q : '0;
            pb_q[0]     <= rd_issue_q ? rd_b_q : '0;
            for (int i = 1; i <= BF_LATENCY; i++) begin
                pen_q[i] <= pen_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pb_q[i]  <= pb_q[i-1];
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_en       = rd_en_q;
    assign rd_addr_a   = rd_a_q;
    assign rd_addr_b   = rd_b_q;
    assign bf_en       = pen_q[0];
    assign twiddle_idx = tw_q;
    assign wr_en       = pen_q[BF_LATENCY];
    assign wr_addr_a   = pa_q[BF_LATENCY];
    assign wr_addr_b   = pb_q[BF_LATENCY];
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    assign out_valid   = out_valid_q;
`else
    assign out_valid   = 1'b0;
    logic w_unused;
    assign w_unused    = out_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_stage_sequencer
// Purpose  : Directed self-checking bench for fft_stage_sequencer (N=8).
//            Cycle-accurate trace checks, start-hold/restart, mid-run reset,
//            and a memory + butterfly scoreboard with an impulse input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_stage_sequencer;

    localparam int N    = 8;
    localparam int AW   = 3;
    localparam int BFL  = 4;
`ifdef FFT_SEQ_BITREV_UNLOAD_EN
    localparam int UL   = 1;
`else
    localparam int UL   = 0;
`endif
    localparam int UL_START = 28;
    localparam int DONE_C   = UL ? 37 : 28;

    logic          clk, rst_n, start;
    logic          busy, done, rd_en, bf_en, wr_en, out_valid;
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [AW-2:0] twiddle_idx;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-derived DIF address/twiddle sequence for N=8, issue index 0..11.
    int exp_a[12]  = '{0, 1, 2, 3,  0, 1, 4, 5,  0, 2, 4, 6};
    int exp_b[12]  = '{4, 5, 6, 7,  2, 3, 6, 7,  1, 3, 5, 7};
    int exp_tw[12] = '{0, 1, 2, 3,  0, 2, 0, 2,  0, 0, 0, 0};
    int bitrev[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
    int cos_t[4]   = '{1024, 724, 0, -724};
    int sin_t[4]   = '{0, 724, 1024, 724};

    fft_stage_sequencer #(.N_POINTS(N), .ADDR_WIDTH(AW), .BF_LATENCY(BFL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .bf_en(bf_en), .twiddle_idx(twiddle_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue index active in cycle c (start accepted = cycle 0), or -1.
    function automatic int issue_idx(input int c);
        int s, r;
        if (c < 1) return -1;
        s = (c - 1) / 9;
        r = (c - 1) % 9;
        if (s < 3 && r < 4) return s * 4 + r;
        return -1;
    endfunction

    function automatic bit in_unload(input int c);
        return (UL != 0) && c >= UL_START && c < UL_START + N;
    endfunction

    task automatic check_cycle(input int c);
        int ii, iw, ir;
        logic [31:0] ea, eb, etw;
        ii = issue_idx(c);
        iw = issue_idx(c - 1);
        ir = issue_idx(c - 1 - BFL);
        ea = 0; eb = 0; etw = 0;
        if (ii >= 0) begin
            ea = exp_a[ii];
            eb = exp_b[ii];
        end else if (in_unload(c)) begin
            ea = bitrev[c - UL_START];
        end
        if (iw >= 0) etw = exp_tw[iw];
        chk($sformatf("rd_en@%0d", c), rd_en, (ii >= 0) || in_unload(c));
        chk($sformatf("rd_addr_a@%0d", c), rd_addr_a, ea);
        chk($sformatf("rd_addr_b@%0d", c), rd_addr_b, eb);
        chk($sformatf("bf_en@%0d", c), bf_en, iw >= 0);
        chk($sformatf("twiddle@%0d", c), twiddle_idx, etw);
        chk($sformatf("wr_en@%0d", c), wr_en, ir >= 0);
        if (ir >= 0) begin
            chk($sformatf("wr_addr_a@%0d", c), wr_addr_a, exp_a[ir]);
            chk($sformatf("wr_addr_b@%0d", c), wr_addr_b, exp_b[ir]);
        end
        chk($sformatf("out_valid@%0d", c), out_valid, in_unload(c - 1));
        chk($sformatf("done@%0d", c), done, c == DONE_C);
        chk($sformatf("busy@%0d", c), busy, c >= 1 && c <= DONE_C);
    endtask

    // Called at #1 inside an IDLE cycle; that cycle becomes cycle 0.
    task automatic run_trace(input bit hold);
        start = 1'b1;
        chk("busy@0", busy, 0);
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= DONE_C + 1; c++) begin
            check_cycle(c);
            if (c <= DONE_C) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Scoreboard: sample memory + pipelined DIF butterfly model.
    typedef struct {
        int ar, ai, br, bi;
    } bf_res_t;
    bf_res_t sbq[$];
    int      mem_re[8], mem_im[8];
    bit      sb_on = 1'b0;
    int      prev_a = 0, prev_b = 0;

    always @(posedge clk) begin
        #2;
        if (sb_on) begin
            if (wr_en) begin
                chk("sb_queue_ready", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    bf_res_t r;
                    r = sbq.pop_front();
                    mem_re[wr_addr_a] = r.ar; mem_im[wr_addr_a] = r.ai;
                    mem_re[wr_addr_b] = r.br; mem_im[wr_addr_b] = r.bi;
                end
            end
            if (bf_en) begin
                bf_res_t r;
                int dr, di;
                r.ar = mem_re[prev_a] + mem_re[prev_b];
                r.ai = mem_im[prev_a] + mem_im[prev_b];
                dr   = mem_re[prev_a] - mem_re[prev_b];
                di   = mem_im[prev_a] - mem_im[prev_b];
                r.br = (dr * cos_t[twiddle_idx] + di * sin_t[twiddle_idx]) >>> 10;
                r.bi = (di * cos_t[twiddle_idx] - dr * sin_t[twiddle_idx]) >>> 10;
                sbq.push_back(r);
            end
            prev_a = rd_addr_a;
            prev_b = rd_addr_b;
        end
    end

    initial begin
        int nwr, nd, nb;
        rst_n = 1'b0;
        start = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr_a", rd_addr_a, 0);
        chk("rst_bf_en", bf_en, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_out_valid", out_valid, 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Single start pulse: full trace
        run_trace(1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Start held for the whole run, then a new run in the cycle after done
        run_trace(1'b1);
        run_trace(1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Reset in cycle 12 aborts the run
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        chk("pre_abort_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_rd_addr_a", rd_addr_a, 0);
        chk("abort_rd_addr_b", rd_addr_b, 0);
        chk("abort_bf_en", bf_en, 0);
        chk("abort_twiddle", twiddle_idx, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_done", done, 0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        nwr = 0; nd = 0; nb = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (wr_en) nwr++;
            if (done)  nd++;
            if (busy)  nb++;
        end
        chk("abort_wr_count", nwr, 0);
        chk("abort_done_count", nd, 0);
        chk("abort_busy_count", nb, 0);
        run_trace(1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Scoreboard run with an impulse at x[0]
        for (int i = 0; i < N; i++) begin
            mem_re[i] = 0;
            mem_im[i] = 0;
        end
        mem_re[0] = 1000;
        sb_on = 1'b1;
        run_trace(1'b0);
        repeat (2) @(posedge clk);
        #3;
        sb_on = 1'b0;
        chk("sb_queue_empty", sbq.size(), 0);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("bin%0d_re", i), mem_re[i], 1000);
            chk($sformatf("bin%0d_im", i), mem_im[i], 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
